// File: rtl/semiring_pkg.sv
// Shared mode encodings and the reduction operator for the semiring reduce lane.
// combine() works on a wide word so every caller can zero-extend its own width into it.
package semiring_pkg;

    typedef enum logic [1:0] {
        MODE_ADD_MAX = 2'b00,
        MODE_MUL_MAX = 2'b01,
        MODE_ADD_MIN = 2'b10,
        MODE_MUL_MIN = 2'b11
    } mode_e;

    localparam int COMB_W = 64;

    typedef logic [COMB_W-1:0] comb_word_t;

    // Reduction operator: mode bit 1 selects min, otherwise max (unsigned compare).
    function automatic comb_word_t combine(mode_e mode, comb_word_t x, comb_word_t y);
        if (mode[1]) begin
            return (x < y) ? x : y;
        end
        return (x > y) ? x : y;
    endfunction

    function automatic logic is_mul(mode_e mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/semiring_tree.sv
// Combinational log2(N)-level max/min reduction of N packed W-bit unsigned values.
module semiring_tree
    import semiring_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic [1:0]     op_sel,
    input  logic [N*W-1:0] data_in,
    output logic [W-1:0]   data_out
);

    localparam int LVL = $clog2(N);

    for (genvar l = 0; l <= LVL; l++) begin : g_lvl
        logic [W-1:0] v [N>>l];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_in
                assign v[i] = data_in[i*W +: W];
            end
        end else begin : g_node
            for (genvar j = 0; j < (N >> l); j++) begin : g_op
                assign v[j] = W'(combine(mode_e'(op_sel),
                                         COMB_W'(g_lvl[l-1].v[2*j]),
                                         COMB_W'(g_lvl[l-1].v[2*j+1])));
            end
        end
    end

    assign data_out = g_lvl[LVL].v[0];

endmodule

// File: rtl/semiring_reduce_pipe.sv
// Three-stage valid/ready semiring dot-reduction lane: S1 products, S2 tree reduction,
// S3 group accumulation and registered result. One global advance stalls every stage together.
module semiring_reduce_pipe
    import semiring_pkg::*;
#(
    parameter int W     = 16,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_a,
    input  logic [N*W-1:0]   in_b,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [1:0]       in_mode,
    input  logic [W-1:0]     in_init,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count
);

    logic             advance;
    mode_e            mode_q;
    mode_e            beat_mode;
    logic [N*W-1:0]   prod;

    logic             s1_valid_q, s1_first_q, s1_last_q;
    mode_e            s1_mode_q;
    logic [N*W-1:0]   s1_prod_q;
    logic [W-1:0]     s1_init_q;
    logic [W-1:0]     tree_out;

    logic             s2_valid_q, s2_first_q, s2_last_q;
    mode_e            s2_mode_q;
    logic [W-1:0]     s2_red_q;
    logic [W-1:0]     s2_init_q;

    logic [W-1:0]     acc_q, acc_d, acc_base;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [CNT_W-1:0] out_count_q;

    assign advance   = ~out_valid_q | out_ready;
    assign in_ready  = advance;
    // Mode is only honoured on a first beat; later beats inherit the group's latched mode.
    assign beat_mode = in_first ? mode_e'(in_mode) : mode_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++) begin
            if (is_mul(beat_mode)) begin
                prod[i*W +: W] = in_a[i*W +: W] * in_b[i*W +: W];
            end else begin
                prod[i*W +: W] = in_a[i*W +: W] + in_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_ADD_MAX;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= MODE_ADD_MAX;
            s1_prod_q  <= '0;
            s1_init_q  <= '0;
        end else if (advance) begin
            if (in_valid && in_first) begin
                mode_q <= mode_e'(in_mode);
            end
            s1_valid_q <= in_valid;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
            s1_mode_q  <= beat_mode;
            s1_prod_q  <= prod;
            s1_init_q  <= in_init;
        end
    end

    semiring_tree #(
        .W (W),
        .N (N)
    ) u_tree (
        .op_sel   (s1_mode_q),
        .data_in  (s1_prod_q),
        .data_out (tree_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_mode_q  <= MODE_ADD_MAX;
            s2_red_q   <= '0;
            s2_init_q  <= '0;
        end else if (advance) begin
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_mode_q  <= s1_mode_q;
            s2_red_q   <= tree_out;
            s2_init_q  <= s1_init_q;
        end
    end

    always_comb begin
        acc_base = s2_first_q ? s2_init_q : acc_q;
        acc_d    = W'(combine(s2_mode_q, COMB_W'(acc_base), COMB_W'(s2_red_q)));
        if (s2_first_q) begin
            cnt_d = CNT_W'(1);
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else if (advance) begin
            if (s2_valid_q) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
            end
            out_valid_q <= s2_valid_q & s2_last_q;
            if (s2_valid_q && s2_last_q) begin
                out_data_q  <= acc_d;
                out_count_q <= cnt_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_semiring_reduce_pipe.sv
// Randomised and directed bench for semiring_reduce_pipe against a group-level reference model.
module tb_semiring_reduce_pipe;

    localparam int W     = 16;
    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   in_a;
    logic [N*W-1:0]   in_b;
    logic             in_first;
    logic             in_last;
    logic [1:0]       in_mode;
    logic [W-1:0]     in_init;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;
    logic rand_ready = 1'b0;

    typedef struct {
        int unsigned data;
        int unsigned count;
    } exp_t;

    exp_t exp_q[$];

    // Reference group state: latched mode, running value, beats seen.
    logic [1:0]  m_mode = 2'b00;
    int unsigned m_acc  = 0;
    int unsigned m_cnt  = 0;

    semiring_reduce_pipe #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_mode   (in_mode),
        .in_init   (in_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned pick(logic minsel, int unsigned x, int unsigned y);
        if (minsel) return (x < y) ? x : y;
        return (x > y) ? x : y;
    endfunction

    function automatic int unsigned ref_beat(logic [1:0] mode, logic [N*W-1:0] a, logic [N*W-1:0] b);
        longint unsigned x, y, p;
        int unsigned r;
        r = 0;
        for (int i = 0; i < N; i++) begin
            x = longint'(a[i*W +: W]);
            y = longint'(b[i*W +: W]);
            p = (mode[0] ? x * y : x + y) % (longint'(1) << W);
            r = (i == 0) ? int'(p) : pick(mode[1], r, int'(p));
        end
        return r;
    endfunction

    // Scoreboard: model every accepted beat, compare every consumed result.
    always @(negedge clk) begin
        exp_t e;
        logic [1:0] md;
        int unsigned base;
        if (rst) begin
            exp_q.delete();
            m_mode = 2'b00;
            m_acc  = 0;
            m_cnt  = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_count", out_count, e.count);
                end
            end
            if (in_valid && in_ready) begin
                if (in_first) m_mode = in_mode;
                md    = m_mode;
                base  = in_first ? int'(in_init) : m_acc;
                m_acc = pick(md[1], base, ref_beat(md, in_a, in_b));
                m_cnt = in_first ? 1 : m_cnt + 1;
                if (in_last) begin
                    e.data  = m_acc;
                    e.count = (m_cnt > 255) ? 255 : m_cnt;
                    exp_q.push_back(e);
                end
            end
        end
    end

    function automatic logic [N*W-1:0] pack4(int unsigned v0, int unsigned v1, int unsigned v2, int unsigned v3);
        return {W'(v3), W'(v2), W'(v1), W'(v0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic first, input logic last, input logic [1:0] mode,
                             input logic [W-1:0] init, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic ok;
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_mode  = mode;
        in_init  = init;
        in_a     = a;
        in_b     = b;
        ok       = 1'b0;
        for (int k = 0; k < 200; k++) begin
            ok = in_ready;
            tick();
            if (ok) break;
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check(tag, 0, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_mode = 2'b00; in_init = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_count", out_count, 0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // Single-beat add/max, with latency.
        send_beat(1, 1, 2'b00, 16'h0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40));
        check("lat_c1_valid", out_valid, 0);
        tick();
        check("lat_c2_valid", out_valid, 0);
        tick();
        check("lat_c3_valid", out_valid, 1);
        check("t1_data", out_data, 44);
        check("t1_count", out_count, 1);

        // Multiply wraps to zero on the first pair.
        send_beat(1, 1, 2'b01, 16'h0, pack4(16'h0100, 3, 3, 3), pack4(16'h0100, 5, 5, 5));
        wait_valid("t2_timeout");
        check("t2_data", out_data, 15);

        // Three-beat add/min group; mode change on beat 2 is ignored.
        send_beat(1, 0, 2'b10, 16'hFFFF, pack4(7, 8, 9, 10), '0);
        send_beat(0, 0, 2'b00, 16'h0, pack4(5, 6, 6, 6), '0);
        send_beat(0, 1, 2'b10, 16'h0, pack4(9, 10, 11, 12), '0);
        wait_valid("t3_timeout");
        check("t3_data", out_data, 5);
        check("t3_count", out_count, 3);
        tick();

        // Back-to-back results with the consumer stalled.
        out_ready = 1'b0;
        send_beat(1, 1, 2'b00, 16'h0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40));
        send_beat(1, 1, 2'b01, 16'h0, pack4(16'h0100, 3, 3, 3), pack4(16'h0100, 5, 5, 5));
        tick();
        for (int k = 0; k < 6; k++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, 44);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("nobubble_valid", out_valid, 1);
        check("nobubble_data", out_data, 15);
        check("nobubble_count", out_count, 1);
        tick();
        check("drained_valid", out_valid, 0);

        // Reset mid-group clears outputs asynchronously.
        send_beat(1, 0, 2'b00, 16'h0, pack4(50, 1, 1, 1), pack4(50, 1, 1, 1));
        send_beat(0, 0, 2'b00, 16'h0, pack4(60, 1, 1, 1), pack4(60, 1, 1, 1));
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_data", out_data, 0);
        check("arst_count", out_count, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        send_beat(1, 1, 2'b00, 16'h0, pack4(2, 0, 0, 0), pack4(10, 0, 0, 0));
        wait_valid("t5_timeout");
        check("t5_data", out_data, 12);
        check("t5_count", out_count, 1);
        tick();

        // Four-beat group, gap-free and then with bubbles; the scoreboard checks data.
        begin
            logic [N*W-1:0] ga [4];
            logic [N*W-1:0] gb [4];
            logic [1:0]     gm;
            gm = 2'($urandom);
            for (int i = 0; i < 4; i++) begin
                ga[i] = {$urandom, $urandom};
                gb[i] = {$urandom, $urandom};
            end
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < 4; i++) begin
                    if (pass == 1) repeat (1 + i % 2) tick();
                    send_beat(i == 0, i == 3, gm, 16'h1234, ga[i], gb[i]);
                end
                wait_valid("gap_timeout");
                check("gap_count", out_count, 4);
                tick();
            end
        end

        // Count saturation on a long group.
        for (int i = 0; i < 260; i++) begin
            send_beat(i == 0, i == 259, 2'b11, 16'h8000, {$urandom, $urandom}, {$urandom, $urandom});
        end
        wait_valid("sat_timeout");
        check("sat_count", out_count, 255);
        tick();

        // Random groups, gaps, modes and back-pressure.
        rand_ready = 1'b1;
        for (int g = 0; g < 40; g++) begin
            int len;
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_beat(i == 0, i == len - 1, 2'($urandom), 16'($urandom),
                          {$urandom, $urandom}, {$urandom, $urandom});
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (20) tick();
        check("all_delivered", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
